// File: rtl/reg_file_dump_reader.sv
// Streams a contiguous, wrapping run of register-bank words over a valid/ready port.
// Each word is captured when it becomes current and held until it is accepted.
module reg_file_dump_reader #(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_REGS    = 32,
    parameter int ADDR_WIDTH  = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [ADDR_WIDTH:0]             count,
    input  logic [WORD_LENGTH*NUM_REGS-1:0] reg_data_flat,
    output logic [WORD_LENGTH-1:0]          out_data,
    output logic [ADDR_WIDTH-1:0]           out_addr,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] TWO     = (ADDR_WIDTH+1)'(2);

    state_t                  state_q, state_d;
    logic [WORD_LENGTH-1:0]  data_q, data_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     rem_q, rem_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;

    logic [WORD_LENGTH-1:0]  bank [NUM_REGS];
    logic [ADDR_WIDTH:0]     eff_cnt;
    logic [ADDR_WIDTH-1:0]   next_addr;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bank
        assign bank[i] = reg_data_flat[i*WORD_LENGTH +: WORD_LENGTH];
    end

    // Power-of-two bank, so the natural overflow of the adder is the wrap.
    assign next_addr = addr_q + ADDR_WIDTH'(1);
    assign eff_cnt   = (count > MAX_CNT) ? MAX_CNT : count;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (eff_cnt == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SEND;
                        valid_d = 1'b1;
                        addr_d  = base_addr;
                        data_d  = bank[base_addr];
                        last_d  = (eff_cnt == ONE);
                        rem_d   = eff_cnt;
                    end
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (rem_q == ONE) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        rem_d   = '0;
                    end else begin
                        addr_d = next_addr;
                        data_d = bank[next_addr];
                        rem_d  = rem_q - ONE;
                        last_d = (rem_q == TWO);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// Directed and randomized dumps checked against a word-list model of the bank:
// each word is the bank value at the moment it becomes current.
module tb_reg_file_dump_reader;

    logic          clk = 1'b0;
    logic          reset, start, out_ready;
    logic [4:0]    base_addr;
    logic [5:0]    count;
    logic [1023:0] reg_data_flat;
    logic [31:0]   out_data;
    logic [4:0]    out_addr;
    logic          out_valid, out_last, busy, done;

    logic [31:0]   bank [32];
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        reg_data_flat = '0;
        for (int i = 0; i < 32; i++) reg_data_flat[i*32 +: 32] = bank[i];
    end

    reg_file_dump_reader #(.WORD_LENGTH(32), .NUM_REGS(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
        .reg_data_flat(reg_data_flat), .out_data(out_data), .out_addr(out_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".last"},  32'(out_last),  32'd0);
        chk({tag, ".busy"},  32'(busy),      32'd0);
        chk({tag, ".done"},  32'(done),      32'd0);
    endtask

    // mode 0: ready always high; mode 1: stall 2nd word 3 cycles while its
    // register changes; mode 2: random ready, random bank writes, stray starts.
    task automatic do_dump(input int base, input int cnt, input int mode);
        int          eff, addr, waited;
        logic [31:0] cur;
        logic        rdy, moved;
        eff = (cnt > 32) ? 32 : cnt;
        @(negedge clk);
        start = 1'b1; base_addr = base[4:0]; count = cnt[5:0]; out_ready = 1'b1;
        addr = base % 32;
        cur  = bank[addr];
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < eff; k++) begin
            waited = 0;
            moved  = 1'b0;
            while (!moved) begin
                chk("word.valid", 32'(out_valid), 32'd1);
                chk("word.addr",  32'(out_addr),  32'(addr));
                chk("word.data",  out_data,       cur);
                chk("word.last",  32'(out_last),  32'(k == eff - 1));
                chk("word.busy",  32'(busy),      32'd1);
                chk("word.done",  32'(done),      32'd0);
                rdy = 1'b1;
                if (mode == 1 && k == 1 && waited < 3) begin
                    rdy = 1'b0;
                    bank[(base + 1) % 32] = $urandom;
                end else if (mode == 2) begin
                    rdy = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) bank[$urandom_range(0, 31)] = $urandom;
                    start     = ($urandom_range(0, 3) == 0);
                    base_addr = 5'($urandom);
                    count     = 6'($urandom);
                end
                if (waited >= 20) begin
                    chk("word.stall_bound", 32'(waited), 32'd0);
                    rdy = 1'b1;
                end
                out_ready = rdy;
                if (rdy) begin
                    addr  = (addr + 1) % 32;
                    cur   = bank[addr];
                    moved = 1'b1;
                end
                waited++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk("done.valid", 32'(out_valid), 32'd0);
        chk("done.last",  32'(out_last),  32'd0);
        chk("done.busy",  32'(busy),      32'd1);
        chk("done.done",  32'(done),      32'd1);
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk_idle("after_done");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = 32'hA000_0000 + 32'(i);
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; count = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset.data", out_data, 32'd0);
        chk("reset.addr", 32'(out_addr), 32'd0);
        reset = 1'b0;

        do_dump(3, 4, 0);
        do_dump(30, 4, 0);
        do_dump(3, 4, 1);
        do_dump(5, 0, 0);
        do_dump(7, 40, 0);
        do_dump(31, 1, 0);
        for (int n = 0; n < 8; n++) do_dump($urandom_range(0, 31), $urandom_range(0, 63), 2);

        // Reset in the middle of a dump, after two words have been taken.
        @(negedge clk);
        start = 1'b1; base_addr = 5'd10; count = 6'd10; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst.before", 32'(out_addr), 32'd12);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("midrst");
        chk("midrst.data", out_data, 32'd0);
        reset = 1'b0;
        do_dump(12, 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
